// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and register/serial outputs.
// The master side drives control and data; the slave side (the register) drives q and taps.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             sout_l;
    logic             sout_r;

    modport master (
        output en, mode, d, sin_r, sin_l,
        input  q, qb, sout_l, sout_r
    );

    modport slave (
        input  en, mode, d, sin_r, sin_l,
        output q, qb, sout_l, sout_r
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, logical shift, rotate, arithmetic shift right, clear.
// q is the only state; qb and the serial taps are combinational views of it.
module univ_shift_reg #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    univ_shift_reg_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    if (WIDTH < 1) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] asr_v;

    // A single-bit register has nothing to rotate or sign-extend, so those modes hold.
    if (WIDTH == 1) begin : g_w1
        assign shl_v = bus.sin_r;
        assign shr_v = bus.sin_l;
        assign rol_v = q_q;
        assign ror_v = q_q;
        assign asr_v = q_q;
    end else begin : g_wn
        assign shl_v = {q_q[WIDTH-2:0], bus.sin_r};
        assign shr_v = {bus.sin_l, q_q[WIDTH-1:1]};
        assign rol_v = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        assign ror_v = {q_q[0], q_q[WIDTH-1:1]};
        assign asr_v = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end

    // Next-state select; an unknown mode propagates X so the fault is visible on q.
    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = bus.d;
                MODE_SHL:  q_d = shl_v;
                MODE_SHR:  q_d = shr_v;
                MODE_ROL:  q_d = rol_v;
                MODE_ROR:  q_d = ror_v;
                MODE_ASR:  q_d = asr_v;
                MODE_CLR:  q_d = '0;
                default:   q_d = 'x;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.qb     = ~q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];

`ifndef SYNTHESIS
    a_mode_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.en |-> !$isunknown(bus.mode));
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic on an 8-bit and a 1-bit
// instance, both compared against an arithmetic model of the register.
module tb_univ_shift_reg;

    localparam int unsigned W8 = 8;
    localparam logic [7:0]  RV8 = 8'hA5;
    localparam logic [0:0]  RV1 = 1'b1;

    localparam int MD_HOLD = 0, MD_LOAD = 1, MD_SHL = 2, MD_SHR = 3;
    localparam int MD_ROL  = 4, MD_ROR  = 5, MD_ASR = 6, MD_CLR = 7;

    logic clk;
    logic rst_n;

    univ_shift_reg_if #(.WIDTH(W8)) b8 ();
    univ_shift_reg_if #(.WIDTH(1))  b1 ();

    univ_shift_reg #(.WIDTH(W8), .RESET_VALUE(RV8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    univ_shift_reg #(.WIDTH(1), .RESET_VALUE(RV1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state and the stimulus last applied to each instance.
    int m8, m1;
    int e8, md8, d8, sr8, sl8;
    int e1, md1, d1, sr1, sl1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register behaviour written as arithmetic on the unsigned value of a w-bit word.
    function automatic int nxt(input int q, input int w, input int e, input int md,
                               input int dd, input int sr, input int sl);
        int p, h;
        p = 1 << w;
        h = p / 2;
        if (e == 0) return q;
        case (md)
            MD_HOLD: return q;
            MD_LOAD: return dd % p;
            MD_SHL:  return (q * 2 + sr) % p;
            MD_SHR:  return q / 2 + sl * h;
            MD_ROL:  return (q * 2) % p + q / h;
            MD_ROR:  return q / 2 + (q % 2) * h;
            MD_ASR:  return q / 2 + ((q >= h) ? h : 0);
            default: return 0;
        endcase
    endfunction

    task automatic drv8(input int e, input int md, input int dd, input int sr, input int sl);
        e8 = e; md8 = md; d8 = dd; sr8 = sr; sl8 = sl;
        b8.en    = 1'(e);
        b8.mode  = 3'(md);
        b8.d     = 8'(dd);
        b8.sin_r = 1'(sr);
        b8.sin_l = 1'(sl);
    endtask

    task automatic drv1(input int e, input int md, input int dd, input int sr, input int sl);
        e1 = e; md1 = md; d1 = dd; sr1 = sr; sl1 = sl;
        b1.en    = 1'(e);
        b1.mode  = 3'(md);
        b1.d     = 1'(dd);
        b1.sin_r = 1'(sr);
        b1.sin_l = 1'(sl);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":q8"},      int'(b8.q),      m8);
        chk({tag, ":qb8"},     int'(b8.qb),     255 - m8);
        chk({tag, ":soutl8"},  int'(b8.sout_l), m8 / 128);
        chk({tag, ":soutr8"},  int'(b8.sout_r), m8 % 2);
        chk({tag, ":q1"},      int'(b1.q),      m1);
        chk({tag, ":qb1"},     int'(b1.qb),     1 - m1);
        chk({tag, ":sout1"},   int'(b1.sout_l) + 2 * int'(b1.sout_r), m1 * 3);
    endtask

    // One rising edge; outputs are sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m8 = int'(RV8);
            m1 = int'(RV1);
        end else begin
            m8 = nxt(m8, 8, e8, md8, d8, sr8, sl8);
            m1 = nxt(m1, 1, e1, md1, d1, sr1, sl1);
        end
        check_outs(tag);
    endtask

    // Pull reset low between edges and confirm the register reacts without a clock.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m8 = int'(RV8);
        m1 = int'(RV1);
        check_outs(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        drv8(0, MD_HOLD, 0, 0, 0);
        drv1(0, MD_HOLD, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Async reset, held across an edge, then released with HOLD.
        async_reset("rst_async");
        chk("rst_A5", int'(b8.q), 'hA5);
        chk("rst_qb5A", int'(b8.qb), 'h5A);
        step("rst_held");
        rst_n = 1'b1;
        drv8(1, MD_HOLD, 0, 0, 0);
        repeat (3) step("hold");
        chk("hold_A5", int'(b8.q), 'hA5);

        // Load, then disabled clear must not change q.
        drv8(1, MD_LOAD, 'h3C, 0, 0);
        step("load");
        chk("load_3C", int'(b8.q), 'h3C);
        drv8(0, MD_CLR, 'hFF, 1, 1);
        repeat (2) step("en0");
        chk("en0_3C", int'(b8.q), 'h3C);

        // Serial-in shift left, watching the outgoing MSB before each edge.
        drv8(1, MD_LOAD, 0, 0, 0);
        step("load00");
        begin
            int bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
            for (int i = 0; i < 8; i++) begin
                drv8(1, MD_SHL, 0, bits[i], 0);
                chk("shl_msb_pre", int'(b8.sout_l), m8 / 128);
                step("shl");
            end
        end
        chk("shl_B2", int'(b8.q), 'hB2);

        // Rotates and arithmetic shift.
        drv8(1, MD_LOAD, 'h81, 0, 0); step("ld81");
        drv8(1, MD_ROL, 0, 0, 0);     step("rol");
        chk("rol_03", int'(b8.q), 'h03);
        drv8(1, MD_ROR, 0, 0, 0);     step("ror1");
        chk("ror_81", int'(b8.q), 'h81);
        step("ror2");
        chk("ror_C0", int'(b8.q), 'hC0);
        drv8(1, MD_LOAD, 'h80, 0, 0); step("ld80");
        drv8(1, MD_ASR, 0, 1, 0);
        repeat (3) step("asr");
        chk("asr_F0", int'(b8.q), 'hF0);
        drv8(1, MD_LOAD, 'h80, 0, 0); step("ld80b");
        drv8(1, MD_SHR, 0, 1, 0);     step("shr");
        chk("shr_40", int'(b8.q), 'h40);

        // Clear gives zero, then reset aborts a shift sequence.
        drv8(1, MD_LOAD, 'hFF, 0, 0); step("ldFF");
        drv8(1, MD_CLR, 'hFF, 1, 1);  step("clr");
        chk("clr_00", int'(b8.q), 0);
        drv8(1, MD_SHL, 0, 1, 0);
        repeat (3) step("shl_seq");
        async_reset("rst_mid_shl");
        chk("rst_mid_A5", int'(b8.q), 'hA5);
        step("rst_mid_held");
        drv8(0, MD_SHL, 0, 1, 0);
        rst_n = 1'b1;
        repeat (2) step("post_rst_en0");
        chk("post_rst_A5", int'(b8.q), 'hA5);
        drv8(1, MD_SHL, 0, 1, 0);
        step("post_rst_shl");
        chk("post_rst_4B", int'(b8.q), 'h4B);

        // Single-bit instance corner cases.
        drv8(0, MD_HOLD, 0, 0, 0);
        drv1(1, MD_LOAD, 0, 0, 0);    step("w1_ld0");
        drv1(1, MD_SHL, 0, 1, 0);     step("w1_shl");
        chk("w1_shl_1", int'(b1.q), 1);
        drv1(1, MD_ROL, 0, 0, 0);     step("w1_rol");
        drv1(1, MD_ROR, 0, 0, 0);     step("w1_ror");
        drv1(1, MD_ASR, 0, 0, 0);     step("w1_asr");
        chk("w1_hold_1", int'(b1.q), 1);
        drv1(1, MD_SHR, 0, 1, 0);     step("w1_shr");
        chk("w1_shr_0", int'(b1.q), 0);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            drv8(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 7),
                 $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
            drv1(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
                #1;
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
